// File: rtl/cdb_fair_bcast_pkg.sv
// rtl/cdb_fair_bcast_pkg.sv - CDB entry types, default port/source counts and grant-bus typedef
`ifndef N
`define N 3
`endif
`ifndef NUM_FU_TOTAL
`define NUM_FU_TOTAL 6
`endif

package cdb_fair_bcast_pkg;
  localparam int PRF_TAG_W = 6;
  localparam int DATA_W    = 32;

  typedef struct packed {
    logic                 valid;
    logic [PRF_TAG_W-1:0] tag;
    logic [DATA_W-1:0]    data;
  } CDB_ENTRY;

  typedef struct packed {
    logic                 valid;
    logic [PRF_TAG_W-1:0] tag;
  } CDB_EARLY_TAG_ENTRY;

  typedef logic [`N-1:0][`NUM_FU_TOTAL-1:0] CDB_GRANT_BUS;

  function automatic CDB_EARLY_TAG_ENTRY early_of(input CDB_ENTRY e);
    CDB_EARLY_TAG_ENTRY t;
    t.valid = e.valid;
    t.tag   = e.tag;
    return t;
  endfunction
endpackage

// File: rtl/cdb_multi_psel.sv
// rtl/cdb_multi_psel.sv - combinational N-of-M priority selector with a promoted priority class
module cdb_multi_psel
  import cdb_fair_bcast_pkg::*;
#(
  parameter int NUM_SRC   = 6,
  parameter int NUM_PORTS = 3
) (
  input  logic [NUM_SRC-1:0]                  req,
  input  logic [NUM_SRC-1:0]                  promoted,
  output logic [NUM_SRC-1:0]                  gnt,
  output logic [NUM_PORTS-1:0][NUM_SRC-1:0]   gnt_bus
);
  logic [NUM_SRC-1:0] taken;
  logic               found;

  // Each port takes the first unclaimed requester, scanning the promoted class before the rest.
  always_comb begin
    taken   = '0;
    gnt_bus = '0;
    found   = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      found = 1'b0;
      for (int cls = 1; cls >= 0; cls--) begin
        for (int s = 0; s < NUM_SRC; s++) begin
          if (!found && req[s] && !taken[s] && (promoted[s] == (cls == 1))) begin
            gnt_bus[p][s] = 1'b1;
            taken[s]      = 1'b1;
            found         = 1'b1;
          end
        end
      end
    end
    gnt = taken;
  end
endmodule

// File: rtl/cdb_fair_bcast.sv
// rtl/cdb_fair_bcast.sv - CDB arbiter and broadcast register; CDB_AGING_EN enables age-based promotion
module cdb_fair_bcast
  import cdb_fair_bcast_pkg::*;
#(
  parameter int NUM_SRC   = 6,
  parameter int NUM_PORTS = `N,
  parameter int AGE_LIMIT = 3
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                squash,
  input  logic [NUM_SRC-1:0]                  req,
  input  CDB_ENTRY [NUM_SRC-1:0]              src_entry,
  output logic [NUM_SRC-1:0]                  grants,
  output logic [NUM_PORTS-1:0][NUM_SRC-1:0]   grant_bus_out,
  output CDB_EARLY_TAG_ENTRY [NUM_PORTS-1:0]  early_tags,
  output CDB_ENTRY [NUM_PORTS-1:0]            cdb_output
);
  logic [NUM_SRC-1:0]                promoted;
  logic [NUM_SRC-1:0]                arb_gnt;
  logic [NUM_PORTS-1:0][NUM_SRC-1:0] arb_bus;
  CDB_ENTRY [NUM_PORTS-1:0]          cdb_next;

`ifdef CDB_AGING_EN
  localparam int AGE_W = $clog2(AGE_LIMIT + 1);
  logic [NUM_SRC-1:0][AGE_W-1:0] age;

  always_comb begin
    promoted = '0;
    for (int s = 0; s < NUM_SRC; s++)
      promoted[s] = (age[s] == AGE_W'(AGE_LIMIT));
  end

  // Denied requesters age toward the limit; a win or an idle cycle restarts the count.
  always_ff @(posedge clock) begin
    if (reset || squash) begin
      age <= '0;
    end else begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (req[s] && !arb_gnt[s]) begin
          if (age[s] != AGE_W'(AGE_LIMIT))
            age[s] <= age[s] + AGE_W'(1);
        end else begin
          age[s] <= '0;
        end
      end
    end
  end
`else
  // Legal AGE_LIMIT is at least 1, so nothing is ever promoted: pure fixed priority.
  assign promoted = {NUM_SRC{AGE_LIMIT == 0}};
`endif

  cdb_multi_psel #(
    .NUM_SRC   (NUM_SRC),
    .NUM_PORTS (NUM_PORTS)
  ) u_psel (
    .req      (req),
    .promoted (promoted),
    .gnt      (arb_gnt),
    .gnt_bus  (arb_bus)
  );

  always_comb begin
    cdb_next = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      for (int s = 0; s < NUM_SRC; s++)
        if (grant_bus_out[p][s])
          cdb_next[p] = cdb_next[p] | src_entry[s];
  end

  always_comb begin
    early_tags = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      if (!reset && !squash)
        early_tags[p] = early_of(cdb_next[p]);
  end

  always_ff @(posedge clock) begin
    if (reset || squash) begin
      grants        <= '0;
      grant_bus_out <= '0;
      cdb_output    <= '0;
    end else begin
      grants        <= arb_gnt;
      grant_bus_out <= arb_bus;
      cdb_output    <= cdb_next;
    end
  end
endmodule

// File: tb/tb_cdb_fair_bcast.sv
// tb/tb_cdb_fair_bcast.sv - scoreboard bench for cdb_fair_bcast with a queue-based reference model
module tb_cdb_fair_bcast;
  import cdb_fair_bcast_pkg::*;

  localparam int NS    = 6;
  localparam int NP    = `N;
  localparam int LIMIT = 3;

  logic                              clock = 1'b0;
  logic                              reset;
  logic                              squash;
  logic [NS-1:0]                     req;
  CDB_ENTRY [NS-1:0]                 src_entry;
  logic [NS-1:0]                     grants;
  logic [NP-1:0][NS-1:0]             grant_bus_out;
  CDB_EARLY_TAG_ENTRY [NP-1:0]       early_tags;
  CDB_ENTRY [NP-1:0]                 cdb_output;

  cdb_fair_bcast #(.NUM_SRC(NS), .NUM_PORTS(NP), .AGE_LIMIT(LIMIT)) dut (
    .clock         (clock),
    .reset         (reset),
    .squash        (squash),
    .req           (req),
    .src_entry     (src_entry),
    .grants        (grants),
    .grant_bus_out (grant_bus_out),
    .early_tags    (early_tags),
    .cdb_output    (cdb_output)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int                          cyc;
    logic [NS-1:0]               g;
    logic [NP-1:0][NS-1:0]       bus;
    CDB_EARLY_TAG_ENTRY [NP-1:0] early;
  } gexp_t;

  typedef struct {
    int                cyc;
    CDB_ENTRY [NP-1:0] out;
  } cexp_t;

  gexp_t gq[$];
  cexp_t cq[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  logic  mon_en = 1'b0;

  // Reference model: grants currently held by the DUT and per-source denial counts.
  logic [NS-1:0]         m_gnt = '0;
  logic [NP-1:0][NS-1:0] m_bus = '0;
  int                    age[NS];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic is_promoted(input int s);
`ifdef CDB_AGING_EN
    return age[s] == LIMIT;
`else
    return (s < 0);
`endif
  endfunction

  task automatic step(input logic [NS-1:0] r, input logic sq, input logic rs);
    CDB_ENTRY [NS-1:0]     ent;
    logic                  kill;
    gexp_t                 ge;
    cexp_t                 ce;
    int                    order[$];
    logic [NS-1:0]         ng;
    logic [NP-1:0][NS-1:0] nb;
    kill = sq | rs;
    for (int s = 0; s < NS; s++) begin
      ent[s].valid = 1'($urandom);
      ent[s].tag   = 6'($urandom);
      ent[s].data  = $urandom;
      if (m_gnt[s]) ent[s].valid = 1'b1;
    end
    req = r; squash = sq; reset = rs; src_entry = ent;

    ge.cyc = cyc; ge.g = m_gnt; ge.bus = m_bus; ge.early = '0;
    ce.cyc = cyc + 1; ce.out = '0;
    for (int p = 0; p < NP; p++)
      for (int s = 0; s < NS; s++)
        if (m_bus[p][s] && !kill) begin
          ce.out[p]         = ent[s];
          ge.early[p].valid = ent[s].valid;
          ge.early[p].tag   = ent[s].tag;
        end
    if (m_gnt != '0) gq.push_back(ge);
    if (m_gnt != '0 && !kill) cq.push_back(ce);

    ng = '0; nb = '0;
    if (!kill) begin
      for (int s = 0; s < NS; s++) if (r[s] && is_promoted(s)) order.push_back(s);
      for (int s = 0; s < NS; s++) if (r[s] && !is_promoted(s)) order.push_back(s);
      for (int p = 0; p < NP && p < order.size(); p++) begin
        nb[p][order[p]] = 1'b1;
        ng[order[p]]    = 1'b1;
      end
    end
    for (int s = 0; s < NS; s++)
      age[s] = (!kill && r[s] && !ng[s]) ? ((age[s] < LIMIT) ? age[s] + 1 : LIMIT) : 0;
    m_gnt = ng; m_bus = nb;
    @(posedge clock); #1;
  endtask

  gexp_t mon_ge;
  cexp_t mon_ce;
  always @(negedge clock) begin
    if (mon_en) begin
      if (grants != '0) begin
        if (gq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL grant_unexpected: got %h expected none (cycle %0d)", grants, cyc);
        end else begin
          mon_ge = gq.pop_front();
          chk("grant_cycle", 128'(cyc), 128'(mon_ge.cyc));
          chk("grants", 128'(grants), 128'(mon_ge.g));
          chk("grant_bus", 128'(grant_bus_out), 128'(mon_ge.bus));
          chk("early_tags", 128'(early_tags), 128'(mon_ge.early));
        end
      end
      if (cdb_output != '0) begin
        if (cq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL cdb_unexpected: got %h expected none (cycle %0d)", cdb_output, cyc);
        end else begin
          mon_ce = cq.pop_front();
          chk("cdb_cycle", 128'(cyc), 128'(mon_ce.cyc));
          chk("cdb_output", 128'(cdb_output), 128'(mon_ce.out));
        end
      end
    end
  end

  int first5;
  int exp_first5;
  logic [NS-1:0] rr;

  initial begin
    for (int s = 0; s < NS; s++) age[s] = 0;
    reset = 1'b1; squash = 1'b0; req = '0; src_entry = '0;
    @(posedge clock); #1;
    chk("reset_early_tags", 128'(early_tags), 128'(0));
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    chk("reset_grants", 128'(grants), 128'(0));
    chk("reset_bus", 128'(grant_bus_out), 128'(0));
    chk("reset_cdb", 128'(cdb_output), 128'(0));
    chk("reset_early_held", 128'(early_tags), 128'(0));
    mon_en = 1'b1;

    step(6'b111111, 1'b0, 1'b0);
    chk("all_req_grants", 128'(grants), 128'(6'b000111));
    chk("all_req_bus", 128'(grant_bus_out), 128'({6'b000100, 6'b000010, 6'b000001}));
    step('0, 1'b0, 1'b0);
    chk("all_req_valid", 128'({cdb_output[2].valid, cdb_output[1].valid, cdb_output[0].valid}), 128'(3'b111));

    step(6'b100000, 1'b0, 1'b0);
    chk("src5_grants", 128'(grants), 128'(6'b100000));
    step('0, 1'b0, 1'b0);
    chk("src5_valid", 128'({cdb_output[2].valid, cdb_output[1].valid, cdb_output[0].valid}), 128'(3'b001));

    step(6'b000011, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0);
    chk("squash_cdb", 128'(cdb_output), 128'(0));
    chk("squash_grants", 128'(grants), 128'(0));

    step(6'b000111, 1'b0, 1'b0);
    step('0, 1'b0, 1'b1);
    chk("midreset_grants", 128'(grants), 128'(0));
    chk("midreset_bus", 128'(grant_bus_out), 128'(0));
    chk("midreset_cdb", 128'(cdb_output), 128'(0));

    first5 = 0;
    for (int i = 1; i <= 20; i++) begin
      step(6'b101111, 1'b0, 1'b0);
      if (grants[5] && first5 == 0) first5 = i;
    end
`ifdef CDB_AGING_EN
    exp_first5 = LIMIT + 1;
`else
    exp_first5 = 0;
`endif
    chk("src5_first_grant", 128'(first5), 128'(exp_first5));
    step('0, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      rr = 6'($urandom);
      if (i % 40 < 20) rr = rr | 6'b100000;
      step(rr, $urandom_range(15) == 0, $urandom_range(63) == 0);
    end
    step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    chk("grant_queue_drained", 128'(gq.size()), 128'(0));
    chk("cdb_queue_drained", 128'(cq.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
